// File: rtl/regfile_pkg.sv
// Register-file geometry shared by the writeback arbiter, the register file and decode.
package regfile_pkg;
    localparam int NUM_REGS   = 4;
    localparam int REG_ADDR_W = 2;
    localparam int REG_DATA_W = 16;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set req bit found
// searching upward from ptr and wrapping modulo N.
module rr_arbiter #(
    parameter int N = 2,
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!found && req[i] && (((int'(ptr) + k) % N) == i)) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among NUM_REQ writeback sources and
// tracks outstanding writes per register so decode can stall on RAW hazards.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [REG_ADDR_W*NUM_REQ-1:0]    req_addr,
    input  logic [REG_DATA_W*NUM_REQ-1:0]    req_data,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic                             reserve_valid,
    input  reg_addr_t                        reserve_addr,
    output logic                             rf_write_enable,
    output reg_addr_t                        rf_write_addr,
    output reg_data_t                        rf_write_data,
    output logic [NUM_REGS-1:0]              busy,
    output logic                             reserve_error
);
    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]  grant;
    logic                xfer;
    reg_addr_t           sel_addr;
    reg_data_t           sel_data;
    logic                wr_en_q;
    reg_addr_t           wr_addr_q;
    reg_data_t           wr_data_q;
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                err_q, err_d;

    rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (grant)
    );

    assign req_ready = reset_n ? grant : '0;

    always_comb begin
        xfer     = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        rr_ptr_d = rr_ptr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                xfer     = 1'b1;
                sel_addr = req_addr[REG_ADDR_W*i +: REG_ADDR_W];
                sel_data = req_data[REG_DATA_W*i +: REG_DATA_W];
                rr_ptr_d = PTR_W'((i + 1) % NUM_REQ);
            end
        end
    end

    // Set is applied after clear so a same-cycle reserve of the retiring register wins.
    always_comb begin
        busy_d = busy_q;
        if (wr_en_q) begin
            busy_d[wr_addr_q] = 1'b0;
        end
        if (reserve_valid) begin
            busy_d[reserve_addr] = 1'b1;
        end
        err_d = err_q | (reserve_valid && busy_q[reserve_addr]
                         && !(wr_en_q && (wr_addr_q == reserve_addr)));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wr_en_q  <= xfer;
            if (xfer) begin
                wr_addr_q <= sel_addr;
                wr_data_q <= sel_data;
            end
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign rf_write_enable = wr_en_q;
    assign rf_write_addr   = wr_addr_q;
    assign rf_write_data   = wr_data_q;
    assign busy            = busy_q;
    assign reserve_error   = err_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a behavioural model of arbitration and scoreboard.
module tb_regfile_wb_arbiter;
    localparam int N = 2;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req_valid;
    logic [2*N-1:0]  req_addr;
    logic [16*N-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            reserve_valid;
    logic [1:0]      reserve_addr;
    logic            rf_write_enable;
    logic [1:0]      rf_write_addr;
    logic [15:0]     rf_write_data;
    logic [3:0]      busy;
    logic            reserve_error;

    int n_checks = 0;
    int n_pass   = 0;

    // model state
    int          m_ptr;
    logic        m_we;
    logic [1:0]  m_addr;
    logic [15:0] m_data;
    logic [3:0]  m_busy;
    logic        m_err;
    logic [N-1:0] last_ready;

    regfile_wb_arbiter #(.NUM_REQ(N)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .req_valid       (req_valid),
        .req_addr        (req_addr),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .reserve_valid   (reserve_valid),
        .reserve_addr    (reserve_addr),
        .rf_write_enable (rf_write_enable),
        .rf_write_addr   (rf_write_addr),
        .rf_write_data   (rf_write_data),
        .busy            (busy),
        .reserve_error   (reserve_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic m_reset();
        m_ptr  = 0;
        m_we   = 1'b0;
        m_addr = '0;
        m_data = '0;
        m_busy = '0;
        m_err  = 1'b0;
    endtask

    // Round-robin from the spec: first valid requester at or after the pointer.
    function automatic int m_pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    // Called just after a posedge: apply inputs, check at negedge, advance model.
    task automatic cycle(input logic [N-1:0] v, input logic [2*N-1:0] a,
                         input logic [16*N-1:0] d, input logic rv, input logic [1:0] ra);
        int g;
        logic [N-1:0] exp_ready;
        logic [3:0] nb;
        req_valid     = v;
        req_addr      = a;
        req_data      = d;
        reserve_valid = rv;
        reserve_addr  = ra;
        @(negedge clk);
        g = m_pick(v, m_ptr);
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        last_ready = req_ready;
        check("req_ready", req_ready, exp_ready);
        check("wr_en",     rf_write_enable, m_we);
        check("wr_addr",   rf_write_addr, m_addr);
        check("wr_data",   rf_write_data, m_data);
        check("busy",      busy, m_busy);
        check("res_err",   reserve_error, m_err);
        nb = m_busy;
        if (m_we) nb[m_addr] = 1'b0;
        if (rv) begin
            if (m_busy[ra] && !(m_we && m_addr == ra)) m_err = 1'b1;
            nb[ra] = 1'b1;
        end
        m_busy = nb;
        if (g >= 0) begin
            m_we   = 1'b1;
            m_addr = a[2*g +: 2];
            m_data = d[16*g +: 16];
            m_ptr  = (g + 1) % N;
        end else begin
            m_we = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle('0, '0, '0, 1'b0, 2'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req_valid = '0; req_addr = '0; req_data = '0;
        reserve_valid = 1'b0; reserve_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_we",   rf_write_enable, 1'b0);
        check("rst_busy", busy, 4'b0000);
        reset_n = 1'b1;
        m_reset();
        @(posedge clk);
        #1;
    endtask

    logic [N-1:0] fair [6];

    initial begin
        m_reset();
        last_ready = '0;
        do_reset();
        idle(10);
        check("idle_ready", last_ready, 2'b00);

        // fairness: both valid, addrs 0 / 1
        for (int i = 0; i < 6; i++) begin
            cycle(2'b11, {2'd1, 2'd0}, {16'h1111 * 16'(i + 1), 16'h2222 * 16'(i + 1)}, 1'b0, 2'd0);
            fair[i] = last_ready;
        end
        for (int i = 0; i < 6; i++)
            check("fair_grant", fair[i], (i % 2 == 0) ? 2'b01 : 2'b10);
        idle(1);

        // single write from requester 0
        cycle(2'b01, {2'd0, 2'd2}, {16'h0000, 16'hBEEF}, 1'b0, 2'd0);
        check("sw_ready", last_ready, 2'b01);
        check("sw_we",    rf_write_enable, 1'b1);
        check("sw_addr",  rf_write_addr, 2'd2);
        check("sw_data",  rf_write_data, 16'hBEEF);
        idle(1);
        check("sw_we_off", rf_write_enable, 1'b0);

        // scoreboard: reserve r3, load writes it four cycles later
        cycle('0, '0, '0, 1'b1, 2'd3);
        check("sb_busy_set", busy, 4'b1000);
        idle(3);
        cycle(2'b10, {2'd3, 2'd0}, {16'hCAFE, 16'h0000}, 1'b0, 2'd0);
        check("sb_write_cyc_busy", busy[3], 1'b1);
        check("sb_write_cyc_we",   rf_write_enable, 1'b1);
        idle(1);
        check("sb_busy_clr", busy, 4'b0000);

        // collision: reserve on the retiring register, then a true double reserve
        cycle('0, '0, '0, 1'b1, 2'd1);
        cycle(2'b01, {2'd0, 2'd1}, {16'h0000, 16'h1234}, 1'b0, 2'd0);
        cycle('0, '0, '0, 1'b1, 2'd1);
        check("col_busy", busy[1], 1'b1);
        check("col_err0", reserve_error, 1'b0);
        cycle('0, '0, '0, 1'b1, 2'd1);
        check("col_err1", reserve_error, 1'b1);
        idle(3);
        check("col_err_sticky", reserve_error, 1'b1);

        // async reset during the write cycle of an accepted transfer
        cycle(2'b01, {2'd0, 2'd2}, {16'h0000, 16'hA5A5}, 1'b1, 2'd0);
        check("ar_we_pre", rf_write_enable, 1'b1);
        #3;
        reset_n = 1'b0;
        #1;
        check("ar_we",    rf_write_enable, 1'b0);
        check("ar_busy",  busy, 4'b0000);
        check("ar_err",   reserve_error, 1'b0);
        check("ar_ready", req_ready, 2'b00);
        req_valid = '0; reserve_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        m_reset();
        @(posedge clk);
        #1;
        idle(3);
        check("ar_no_write", rf_write_enable, 1'b0);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            cycle(N'($urandom_range(0, 3)), (2*N)'($urandom), {16'($urandom), 16'($urandom)},
                  ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)));
        end
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
